// File: rtl/ps2_command_sender_if.sv
// Command handshake between a host-side requester and the PS/2 command sender.
//   command       : byte to transmit, sampled when send_command is accepted
//   send_command  : request strobe, honoured only while busy is low
//   busy          : transfer in progress (acceptance until terminating pulse)
//   command_sent  : one-cycle pulse, byte sent and device acknowledged
//   error_no_ack  : one-cycle pulse, device left the ACK bit high
//   error_timeout : one-cycle pulse, device stopped clocking
interface ps2_command_sender_if;
    logic [7:0] command;
    logic       send_command;
    logic       busy;
    logic       command_sent;
    logic       error_no_ack;
    logic       error_timeout;

    modport master (
        output command, send_command,
        input  busy, command_sent, error_no_ack, error_timeout
    );

    modport slave (
        input  command, send_command,
        output busy, command_sent, error_no_ack, error_timeout
    );
endinterface

// File: rtl/ps2_command_sender.sv
// Host-to-device PS/2 transmitter: inhibits the clock, raises request-to-send,
// shifts {stop, odd parity, command} out LSB first on device-generated falling
// clock edges, then checks the device ACK and waits for the bus to go idle.
// Ports:
//   CLOCK_50   : system clock, rising edge
//   reset      : asynchronous, active-high
//   cmd_if     : command handshake (slave side)
//   ps2_clk_in : raw PS2_CLK pin (asynchronous)
//   ps2_dat_in : raw PS2_DAT pin (asynchronous)
//   ps2_clk_oe : 1 = pull PS2_CLK low
//   ps2_dat_oe : 1 = pull PS2_DAT low
module ps2_command_sender #(
    parameter int unsigned INHIBIT_CYCLES       = 6000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    ps2_command_sender_if.slave  cmd_if,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_dat_in,
    output logic                 ps2_clk_oe,
    output logic                 ps2_dat_oe
);

    localparam int unsigned CNT_W      = 20;
    localparam int unsigned EDGE_W     = 4;
    localparam int unsigned FRAME_W    = 10;
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(BIT_TIMEOUT_CYCLES - 1);
    localparam logic [EDGE_W-1:0] LAST_DATA_EDGE = EDGE_W'(9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t               state;
    logic [1:0]           clk_sync;
    logic [1:0]           dat_sync;
    logic                 clk_prev;
    logic [FRAME_W-1:0]   frame;
    logic [CNT_W-1:0]     timer;
    logic [EDGE_W-1:0]    edge_cnt;
    logic                 busy_q;
    logic                 sent_q;
    logic                 no_ack_q;
    logic                 timeout_q;
    logic                 clk_fall_c;
    logic                 timer_done_c;

    assign cmd_if.busy          = busy_q;
    assign cmd_if.command_sent  = sent_q;
    assign cmd_if.error_no_ack  = no_ack_q;
    assign cmd_if.error_timeout = timeout_q;

    assign clk_fall_c   = clk_prev & ~clk_sync[1];
    assign timer_done_c = (timer == '0);

    // Pin synchronizers; reset to the idle (released, pulled-up) level.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    // Transfer sequencer with registered line drivers and status pulses.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            no_ack_q   <= 1'b0;
            timeout_q  <= 1'b0;
            frame      <= '0;
            timer      <= '0;
            edge_cnt   <= '0;
        end else begin
            sent_q    <= 1'b0;
            no_ack_q  <= 1'b0;
            timeout_q <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (cmd_if.send_command) begin
                        frame      <= {1'b1, ~^cmd_if.command, cmd_if.command};
                        timer      <= INHIBIT_LOAD;
                        ps2_clk_oe <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (timer_done_c) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= S_REQ;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                // Data already low; releasing the clock hands it to the device.
                S_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    timer      <= START_LOAD;
                    state      <= S_WAIT_START;
                end

                S_WAIT_START: begin
                    if (clk_fall_c) begin
                        ps2_dat_oe <= ~frame[0];
                        frame      <= {1'b0, frame[FRAME_W-1:1]};
                        edge_cnt   <= EDGE_W'(1);
                        timer      <= BIT_LOAD;
                        state      <= S_SHIFT;
                    end else if (timer_done_c) begin
                        ps2_dat_oe <= 1'b0;
                        busy_q     <= 1'b0;
                        timeout_q  <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                // Edge 10 shifts out the stop bit, which releases data for ACK.
                S_SHIFT: begin
                    if (clk_fall_c) begin
                        ps2_dat_oe <= ~frame[0];
                        frame      <= {1'b0, frame[FRAME_W-1:1]};
                        edge_cnt   <= edge_cnt + EDGE_W'(1);
                        timer      <= BIT_LOAD;
                        if (edge_cnt == LAST_DATA_EDGE) begin
                            state <= S_ACK;
                        end
                    end else if (timer_done_c) begin
                        ps2_dat_oe <= 1'b0;
                        busy_q     <= 1'b0;
                        timeout_q  <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                S_ACK: begin
                    if (clk_fall_c) begin
                        timer <= BIT_LOAD;
                        if (dat_sync[1]) begin
                            no_ack_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            state <= S_WAIT_IDLE;
                        end
                    end else if (timer_done_c) begin
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_sync[1] && dat_sync[1]) begin
                        sent_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (clk_fall_c) begin
                        timer <= BIT_LOAD;
                    end else if (timer_done_c) begin
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
